// File: rtl/fum_mips_pkg.sv
// Shared definitions for the 16-bit FUM MIPS core.
//  - Default datapath widths.
//  - Opcode encodings for instr[15:12].
//  - ALU operation encodings.
//  - ctrl_t: the 15-bit control bundle produced by the opcode decoder.
//  - CTRL_BUBBLE: the all-zero control bundle used for a pipeline bubble.
package fum_mips_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_AW_DEF = 4;
  localparam int PC_W_DEF   = 16;

  // Opcodes (instr[15:12])
  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0001;
  localparam logic [3:0] OP_SLTI  = 4'b0010;
  localparam logic [3:0] OP_ANDI  = 4'b0011;
  localparam logic [3:0] OP_ORI   = 4'b0100;
  localparam logic [3:0] OP_NORI  = 4'b0101;
  localparam logic [3:0] OP_LUI   = 4'b0110;
  localparam logic [3:0] OP_LW    = 4'b0111;
  localparam logic [3:0] OP_SW    = 4'b1000;
  localparam logic [3:0] OP_BEQ   = 4'b1001;
  localparam logic [3:0] OP_BNE   = 4'b1010;
  localparam logic [3:0] OP_BGT   = 4'b1011;
  localparam logic [3:0] OP_BLT   = 4'b1100;
  localparam logic [3:0] OP_JUMP  = 4'b1111;

  // ALU operations
  localparam logic [3:0] ALU_NOP = 4'd0;
  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_OR  = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_LUI = 4'd7;

  // Decoder control bundle (15 bits)
  typedef struct packed {
    logic       reg_dst;
    logic       jump;
    logic       br_eq;
    logic       br_neq;
    logic       br_gt;
    logic       br_lt;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: combinational load-use hazard detection.
//  Decodes which source registers the ID instruction reads (from its opcode)
//  and compares them with the destination of a load currently in EX.
// Ports:
//  id_valid, id_opcode, id_rs_addr, id_rt_addr   ID instruction
//  ex_valid, ex_mem_read, ex_dst_addr            EX instruction
//  hazard_stall                                  stall IF/ID, bubble EX
module hazard_detect
  import fum_mips_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_dst_addr,
  output logic              hazard_stall
);

  logic uses_rs;
  logic uses_rt;

  // rt is a source only for R-type, stores and compare-branches; for
  // I-type ALU ops and loads it is the destination and must not stall.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    uses_rs = (id_opcode != OP_JUMP);
    uses_rt = 1'b0;
    case (id_opcode)
      OP_RTYPE, OP_SW, OP_BEQ, OP_BNE, OP_BGT, OP_BLT: uses_rt = 1'b1;
      default: ;
    endcase
  end

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard_stall = id_valid & ex_valid & ex_mem_read
                      & (ex_dst_addr != '0)
                      & ((uses_rs & (id_rs_addr == ex_dst_addr))
                       | (uses_rt & (id_rt_addr == ex_dst_addr)));

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the 16-bit FUM MIPS core.
//  Registers the decoder control bundle, operands, immediate and PC into EX,
//  stalls IF/ID for one cycle on a load-use hazard (injecting a bubble), and
//  turns the ID instruction into a bubble on an EX branch/jump flush.
// Ports:
//  clk, rst_n                 clock, synchronous active-low reset
//  id_*                       ID-stage instruction, control and operands
//  ex_flush                   kill the ID instruction (branch/jump in EX)
//  hazard_stall               combinational: hold PC and IF/ID this cycle
//  ex_valid, ex_*             registered EX-stage copies
//  ex_dst_addr                registered (reg_dst ? rd : rt)
// Configuration:
//  ID_EX_PERF_EN              adds saturating perf_stall_cnt / perf_flush_cnt
module id_ex_stage
  import fum_mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int PC_W   = PC_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_opcode,
  input  logic              id_reg_dst,
  input  logic              id_jump,
  input  logic              id_br_eq,
  input  logic              id_br_neq,
  input  logic              id_br_gt,
  input  logic              id_br_lt,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [3:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [PC_W-1:0]   id_pc,
  input  logic              ex_flush,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_jump,
  output logic              ex_br_eq,
  output logic              ex_br_neq,
  output logic              ex_br_gt,
  output logic              ex_br_lt,
  output logic              ex_mem_read,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic [3:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rs_addr,
  output logic [REG_AW-1:0] ex_rt_addr,
  output logic [REG_AW-1:0] ex_dst_addr,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PC_W-1:0]   ex_pc
`ifdef ID_EX_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt,
  output logic [15:0]       perf_flush_cnt
`endif
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  bubble;

  assign id_ctrl = '{reg_dst:    id_reg_dst,
                     jump:       id_jump,
                     br_eq:      id_br_eq,
                     br_neq:     id_br_neq,
                     br_gt:      id_br_gt,
                     br_lt:      id_br_lt,
                     mem_read:   id_mem_read,
                     mem_to_reg: id_mem_to_reg,
                     mem_write:  id_mem_write,
                     alu_src:    id_alu_src,
                     reg_write:  id_reg_write,
                     alu_op:     id_alu_op};

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs_addr   (id_rs_addr),
    .id_rt_addr   (id_rt_addr),
    .ex_valid     (ex_valid),
    .ex_mem_read  (ex_ctrl.mem_read),
    .ex_dst_addr  (ex_dst_addr),
    .hazard_stall (hazard_stall)
  );

  // Flush and stall both turn this edge's load into a bubble; the stall still
  // reaches the PC logic, which gives the branch target priority.
  assign bubble = ex_flush | hazard_stall;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_rs_addr  <= '0;
      ex_rt_addr  <= '0;
      ex_dst_addr <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_rs_addr  <= '0;
      ex_rt_addr  <= '0;
      ex_dst_addr <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else begin
      ex_valid    <= id_valid;
      // An empty ID slot must not carry any side-effecting control into EX.
      ex_ctrl     <= id_valid ? id_ctrl : CTRL_BUBBLE;
      ex_rs_addr  <= id_rs_addr;
      ex_rt_addr  <= id_rt_addr;
      ex_dst_addr <= id_reg_dst ? id_rd_addr : id_rt_addr;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
    end
  end

  assign ex_reg_dst    = ex_ctrl.reg_dst;
  assign ex_jump       = ex_ctrl.jump;
  assign ex_br_eq      = ex_ctrl.br_eq;
  assign ex_br_neq     = ex_ctrl.br_neq;
  assign ex_br_gt      = ex_ctrl.br_gt;
  assign ex_br_lt      = ex_ctrl.br_lt;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_alu_op     = ex_ctrl.alu_op;

`ifdef ID_EX_PERF_EN
  // Event counters saturate rather than wrap so a long run never reads low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hazard_stall && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (ex_flush && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
